// File: rtl/contador_pkg.sv
// Shared types and default widths for the up/down event counter and its
// hysteresis threshold sub-block.
package contador_pkg;

    typedef enum logic {WRAP, SATURATE} count_mode_t;
    typedef enum logic {BELOW, ABOVE} thr_state_t;

    localparam int N_DEF = 16;
    localparam int S_DEF = 4;
    localparam int W_DEF = 8;

endpackage

// File: rtl/threshold_hyst.sv
// Two-state hysteresis comparator: rises above thr_hi, falls below thr_lo,
// evaluated on an already-registered value, so the flag lags it by one cycle.
module threshold_hyst
    import contador_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] value,
    input  logic [N-1:0] thr_hi,
    input  logic [N-1:0] thr_lo,
    output logic         threshold
);

    thr_state_t r_state;
    thr_state_t w_state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BELOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            BELOW: if (value > thr_hi) w_state_next = ABOVE;
            ABOVE: if (value < thr_lo) w_state_next = BELOW;
            default: w_state_next = BELOW;
        endcase
    end

    assign threshold = (r_state == ABOVE);

endmodule

// File: rtl/contador_updown_mod.sv
// Programmable-step up/down counter with limit, wrap/saturate mode,
// terminal-event pulse, saturating wrap counter and hysteretic threshold flag.
module contador_updown_mod
    import contador_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int S = S_DEF,
    parameter int W = W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         dec,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic [S-1:0] step,
    input  logic [N-1:0] limit,
    input  logic         mode,
    input  logic [N-1:0] thr_hi,
    input  logic [N-1:0] thr_lo,
    output logic [N-1:0] counter,
    output logic         threshold,
    output logic         at_zero,
    output logic         at_max,
    output logic         tc_pulse,
    output logic [W-1:0] wrap_count
);

    logic [N-1:0] r_counter;
    logic         r_tc_pulse;
    logic [W-1:0] r_wrap_count;

    logic [N:0]   w_cnt_ext;
    logic [N:0]   w_step_ext;
    logic [N:0]   w_limit_ext;
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic [N-1:0] w_next;
    logic         w_wrap_evt;
    logic         w_sat_evt;
    count_mode_t  w_mode;

    // One extra bit so the up-sum can never overflow before the limit compare.
    assign w_cnt_ext   = {1'b0, r_counter};
    assign w_step_ext  = {{(N + 1 - S){1'b0}}, step};
    assign w_limit_ext = {1'b0, limit};
    assign w_sum       = w_cnt_ext + w_step_ext;
    assign w_diff      = w_cnt_ext - w_step_ext;
    assign w_mode      = count_mode_t'(mode);

    always_comb begin
        w_next     = r_counter;
        w_wrap_evt = 1'b0;
        w_sat_evt  = 1'b0;
        if (load) begin
            w_next = (load_value > limit) ? limit : load_value;
        end else if (enable && (step != '0)) begin
            if (!dec) begin
                if (w_sum <= w_limit_ext) begin
                    w_next = w_sum[N-1:0];
                end else if (w_mode == SATURATE) begin
                    w_next    = limit;
                    w_sat_evt = (r_counter != limit);
                end else begin
                    w_next     = '0;
                    w_wrap_evt = 1'b1;
                end
            end else begin
                // A limit lowered under the count is honoured by clamping on the way down.
                if (w_cnt_ext >= w_step_ext) begin
                    w_next = (w_diff > w_limit_ext) ? limit : w_diff[N-1:0];
                end else if (w_mode == SATURATE) begin
                    w_next    = '0;
                    w_sat_evt = (r_counter != '0);
                end else begin
                    w_next     = limit;
                    w_wrap_evt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_counter    <= '0;
            r_tc_pulse   <= 1'b0;
            r_wrap_count <= '0;
        end else begin
            r_counter  <= w_next;
            r_tc_pulse <= w_wrap_evt | w_sat_evt;
            if (w_wrap_evt && (r_wrap_count != '1)) begin
                r_wrap_count <= r_wrap_count + 1'b1;
            end
        end
    end

    threshold_hyst #(
        .N(N)
    ) u_threshold_hyst (
        .clock    (clock),
        .reset    (reset),
        .value    (r_counter),
        .thr_hi   (thr_hi),
        .thr_lo   (thr_lo),
        .threshold(threshold)
    );

    assign counter    = r_counter;
    assign tc_pulse   = r_tc_pulse;
    assign wrap_count = r_wrap_count;
    assign at_zero    = (r_counter == '0);
    assign at_max     = (r_counter == limit);

endmodule

// File: tb/tb_contador_updown_mod.sv
// Directed bench for contador_updown_mod (N=16, S=4, W=8) with hand-computed
// expectations checked through immediate assertions.
module tb_contador_updown_mod;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        dec;
    logic        load;
    logic [15:0] load_value;
    logic [3:0]  step;
    logic [15:0] limit;
    logic        mode;
    logic [15:0] thr_hi;
    logic [15:0] thr_lo;
    logic [15:0] counter;
    logic        threshold;
    logic        at_zero;
    logic        at_max;
    logic        tc_pulse;
    logic [7:0]  wrap_count;

    int checks = 0;
    int errors = 0;

    contador_updown_mod #(
        .N(16),
        .S(4),
        .W(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .dec       (dec),
        .load      (load),
        .load_value(load_value),
        .step      (step),
        .limit     (limit),
        .mode      (mode),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .counter   (counter),
        .threshold (threshold),
        .at_zero   (at_zero),
        .at_max    (at_max),
        .tc_pulse  (tc_pulse),
        .wrap_count(wrap_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] up_cnt [6];
        logic        up_thr [6];
        logic [15:0] dn_cnt [6];
        logic        dn_thr [6];
        int          tc_bad;

        reset      = 1'b1;
        enable     = 1'b0;
        dec        = 1'b0;
        load       = 1'b0;
        load_value = '0;
        step       = 4'd1;
        limit      = 16'd1000;
        mode       = 1'b0;
        thr_hi     = 16'hFFFF;
        thr_lo     = 16'h0000;
        tick();
        reset = 1'b0;
        check("rst_counter", counter, 0);
        check("rst_threshold", threshold, 0);
        check("rst_tc", tc_pulse, 0);
        check("rst_wrapcnt", wrap_count, 0);
        check("rst_at_zero", at_zero, 1);

        // Reset mid-count
        load = 1'b1; load_value = 16'd100;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        check("mid_count", counter, 101);
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b0;
        check("midrst_counter", counter, 0);
        check("midrst_wrapcnt", wrap_count, 0);
        check("midrst_tc", tc_pulse, 0);

        // Wrap up: limit 9, step 3
        do_reset();
        limit = 16'd9; mode = 1'b0; step = 4'd3; dec = 1'b0; enable = 1'b1;
        tick(); check("wrap_c3", counter, 3); check("wrap_tc3", tc_pulse, 0);
        tick(); check("wrap_c6", counter, 6); check("wrap_tc6", tc_pulse, 0);
        tick(); check("wrap_c9", counter, 9); check("wrap_atmax", at_max, 1);
        check("wrap_tc9", tc_pulse, 0);
        tick(); check("wrap_c0", counter, 0); check("wrap_tc0", tc_pulse, 1);
        check("wrap_cnt1", wrap_count, 1);
        tick(); check("wrap_c3b", counter, 3); check("wrap_tc_drop", tc_pulse, 0);
        enable = 1'b0;

        // Saturate down: limit 50, load 5, step 2
        do_reset();
        limit = 16'd50; mode = 1'b1; load = 1'b1; load_value = 16'd5;
        tick(); check("sat_load", counter, 5); check("sat_load_tc", tc_pulse, 0);
        load = 1'b0; dec = 1'b1; step = 4'd2; enable = 1'b1;
        tick(); check("sat_c3", counter, 3); check("sat_tc3", tc_pulse, 0);
        tick(); check("sat_c1", counter, 1); check("sat_tc1", tc_pulse, 0);
        tick(); check("sat_c0", counter, 0); check("sat_tc0", tc_pulse, 1);
        tick(); check("sat_c0b", counter, 0); check("sat_tc0b", tc_pulse, 0);
        tick(); check("sat_c0c", counter, 0); check("sat_tc0c", tc_pulse, 0);
        check("sat_wrapcnt", wrap_count, 0);
        check("sat_at_zero", at_zero, 1);

        // Load priority over count, clamped to limit
        load = 1'b1; load_value = 16'd200; limit = 16'd120; dec = 1'b0; mode = 1'b0;
        tick(); check("load_clamp", counter, 120); check("load_tc", tc_pulse, 0);
        check("load_atmax", at_max, 1);
        // Limit lowered under count: down clamps, up wraps
        load = 1'b0; limit = 16'd100; dec = 1'b1; step = 4'd1;
        tick(); check("dn_clamp", counter, 100); check("dn_clamp_tc", tc_pulse, 0);
        limit = 16'd50; dec = 1'b0;
        tick(); check("up_over_limit", counter, 0); check("up_over_tc", tc_pulse, 1);
        check("up_over_wrapcnt", wrap_count, 1);
        enable = 1'b0;

        // Hysteresis: thr_hi 20, thr_lo 10, step 5
        do_reset();
        limit = 16'd1000; mode = 1'b0; thr_hi = 16'd20; thr_lo = 16'd10;
        step = 4'd5; dec = 1'b0; enable = 1'b1;
        up_cnt = '{16'd5, 16'd10, 16'd15, 16'd20, 16'd25, 16'd30};
        up_thr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dn_cnt = '{16'd25, 16'd20, 16'd15, 16'd10, 16'd5, 16'd0};
        dn_thr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("hyst_up_cnt%0d", i), counter, up_cnt[i]);
            check($sformatf("hyst_up_thr%0d", i), threshold, up_thr[i]);
        end
        dec = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("hyst_dn_cnt%0d", i), counter, dn_cnt[i]);
            check($sformatf("hyst_dn_thr%0d", i), threshold, dn_thr[i]);
        end
        step = 4'd0;
        tick(); check("step0_hold", counter, 0); check("step0_tc", tc_pulse, 0);
        thr_hi = 16'hFFFF; thr_lo = 16'h0000;

        // Saturate up already at limit: no event
        limit = 16'd0; mode = 1'b1; dec = 1'b0; step = 4'd1;
        tick(); check("satmax_cnt", counter, 0); check("satmax_tc", tc_pulse, 0);

        // Wrap-count saturation: limit 0 wraps every cycle
        do_reset();
        limit = 16'd0; mode = 1'b0; step = 4'd1; dec = 1'b0; enable = 1'b1;
        tick();
        check("wc_first", wrap_count, 1);
        check("wc_first_tc", tc_pulse, 1);
        tc_bad = 0;
        for (int i = 1; i < 300; i++) begin
            tick();
            if (tc_pulse !== 1'b1) tc_bad++;
        end
        check("wc_tc_every_cycle_bad", tc_bad, 0);
        check("wc_sat", wrap_count, 255);
        check("wc_counter", counter, 0);
        tick();
        check("wc_hold", wrap_count, 255);
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
